operand_feeder: RTL and testbench
=================================

OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- FEATURE_MAP_WIDTH, 1024, x extent
- FEATURE_MAP_HEIGHT, 1024, y extent
- INPUT_NB_CHANNELS, 64, ch_in extent
- OUTPUT_NB_CHANNELS, 64, ch_out extent
- KERNEL_SIZE, 3, odd kernel edge
- IO_DATA_WIDTH, 8, operand width
- ADDR_WIDTH, 32, memory address width

REQ-002 Ports (name, direction, width, meaning), one per line. The block has one clock; reset is synchronous and active-high.
- clk, in, 1, clock
- rst_in, in, 1, synchronous active-high reset
- start, in, 1, start pulse
- running, out, 1, high outside IDLE
- done, out, 1, one-cycle pulse on return to IDLE
- fm_re, out, 1, feature-map read
- fm_addr, out, ADDR_WIDTH, feature-map address
- fm_rdata, in, IO_DATA_WIDTH, feature-map data (1-cycle latency)
- k_re, out, 1, kernel read
- k_addr, out, ADDR_WIDTH, kernel address
- k_rdata, in, IO_DATA_WIDTH, kernel data (1-cycle latency)
- a_valid, out, 1, activation valid
- a_data, out, IO_DATA_WIDTH, activation
- a_ready, in, 1, consumer ready
- b_valid, out, 1, weight valid
- b_data, out, IO_DATA_WIDTH, weight
- b_ready, in, 1, consumer ready

Function
REQ-003 Pair order: for x, for y, for ch_in, for ch_out, for k_v, for k_h (k_h innermost); exactly one (a,b) pair per iteration.
REQ-004 Pair count: W*H*Cin*Cout*K*K.
REQ-005 Padding: P = (K-1)/2, iy = y+k_v-P, ix = x+k_h-P.
REQ-006 fm_addr = (iy*W+ix)*Cin+ch_in. If iy or ix is out of range: no fm_re, and a_data=0 for that pair.
REQ-007 k_addr = ((ch_out*Cin+ch_in)*K+k_v)*K+k_h. k_re fires for every pair.
REQ-008 Address arithmetic uses signed 33-bit intermediates for the bounds check; addresses are truncated to ADDR_WIDTH.
REQ-009 a_valid and b_valid are always equal (joint pair).
REQ-010 A pair transfers on a cycle with a_valid && a_ready && b_valid && b_ready.
- a_valid/b_valid never deassert before transfer.
- a_data/b_data are stable while stalled.
REQ-011 Data returned from memory is captured into a 2-entry FIFO; the FIFO head drives a_data/b_data.
REQ-012 A read issues in a cycle only if (FIFO occupancy + in-flight reads) < 2; throughput is 1 pair/cycle with ready held high.
REQ-013 Pop and push in the same cycle are both honoured (occupancy unchanged).
REQ-014 FSM states:
- IDLE -> STREAM on start.
- STREAM -> DRAIN after the read for the last pair issues.
- DRAIN -> IDLE when the FIFO is empty and nothing is in flight; done=1 in that transition cycle.
REQ-015 start is ignored outside IDLE.
REQ-016 Loop counters advance only on issue and wrap to 0 after their last value.
REQ-017 First valid pair appears 2 cycles after the start cycle (issue, then capture).

Reset
REQ-018 rst_in at any clock edge forces IDLE and clears all counters, the FIFO and in-flight state. A mid-stream reset discards all data.
REQ-019 While rst_in is high and after reset, all outputs are 0: running, done, fm_re, k_re, a_valid, b_valid, addresses, data.

Structure
REQ-020 The FSM state enum (IDLE, STREAM, DRAIN) lives in shared package conv_pkg.
REQ-021 The FIFO is sub-module operand_fifo (2 entries, width 2*IO_DATA_WIDTH, push/pop/full/empty).
REQ-022 Counter width is 32 bits.

Verification
Configuration for all scenarios: W=H=4, Cin=Cout=2, K=3.
REQ-023 start with ready held high -> 576 pairs on consecutive cycles, first pair at start+2. done is 1 cycle after the last transfer.
REQ-024 Pair 0 (x=y=0, k_v=k_h=0) -> a_data=0, fm_re low. Pair 4 (x=y=0, k_v=k_h=1) -> fm_addr=0, k_addr=4.
REQ-025 ready toggling 1/0 every cycle -> 576 transfers, no loss or duplication, data stable during stalls, FIFO never overflows.
REQ-026 ready low for 10 cycles mid-stream -> at most 2 reads outstanding, then in-order resumption.
REQ-027 rst_in for 1 cycle at pair 100 -> all outputs 0 next cycle. A new start restarts from pair 0.
REQ-028 start pulsed during STREAM -> ignored, total still 576.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution operand feeder.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   localparam int unsigned CNT_WIDTH = 32;

   // True when a signed coordinate lies inside [0, lim).
   function automatic logic in_bounds(input logic signed [32:0] v,
                                      input logic signed [32:0] lim);
      return (v >= 33'sd0) && (v < lim);
   endfunction

endpackage

// File: rtl/operand_fifo.sv
// Two-entry FIFO holding captured {activation, weight} pairs.
module operand_fifo #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage, pointers and occupancy; simultaneous push and pop keep the count.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         for (int unsigned i = 0; i < 2; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= !wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= !rd_ptr;
         end
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/operand_feeder.sv
// Walks the convolution loop nest, reads feature-map and kernel operands,
// and streams them as joint (activation, weight) pairs.
module operand_feeder
   import conv_pkg::*;
#(
   parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
   parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
   parameter int unsigned INPUT_NB_CHANNELS  = 64,
   parameter int unsigned OUTPUT_NB_CHANNELS = 64,
   parameter int unsigned KERNEL_SIZE        = 3,
   parameter int unsigned IO_DATA_WIDTH      = 8,
   parameter int unsigned ADDR_WIDTH         = 32
) (
   input  logic                     clk,
   input  logic                     rst_in,
   input  logic                     start,
   output logic                     running,
   output logic                     done,
   output logic                     fm_re,
   output logic [ADDR_WIDTH-1:0]    fm_addr,
   input  logic [IO_DATA_WIDTH-1:0] fm_rdata,
   output logic                     k_re,
   output logic [ADDR_WIDTH-1:0]    k_addr,
   input  logic [IO_DATA_WIDTH-1:0] k_rdata,
   output logic                     a_valid,
   output logic [IO_DATA_WIDTH-1:0] a_data,
   input  logic                     a_ready,
   output logic                     b_valid,
   output logic [IO_DATA_WIDTH-1:0] b_data,
   input  logic                     b_ready
);

   localparam int unsigned DW2 = 2 * IO_DATA_WIDTH;
   localparam int unsigned PAD = (KERNEL_SIZE - 1) / 2;

   localparam logic [CNT_WIDTH-1:0] W_C    = CNT_WIDTH'(FEATURE_MAP_WIDTH);
   localparam logic [CNT_WIDTH-1:0] H_C    = CNT_WIDTH'(FEATURE_MAP_HEIGHT);
   localparam logic [CNT_WIDTH-1:0] CIN_C  = CNT_WIDTH'(INPUT_NB_CHANNELS);
   localparam logic [CNT_WIDTH-1:0] COUT_C = CNT_WIDTH'(OUTPUT_NB_CHANNELS);
   localparam logic [CNT_WIDTH-1:0] K_C    = CNT_WIDTH'(KERNEL_SIZE);

   localparam logic signed [32:0] W_S   = signed'(33'(FEATURE_MAP_WIDTH));
   localparam logic signed [32:0] H_S   = signed'(33'(FEATURE_MAP_HEIGHT));
   localparam logic signed [32:0] CIN_S = signed'(33'(INPUT_NB_CHANNELS));
   localparam logic signed [32:0] PAD_S = signed'(33'(PAD));

   state_t state_q, state_d;
   logic   done_c;

   logic [CNT_WIDTH-1:0] x_q, y_q, ci_q, co_q, kv_q, kh_q;
   logic x_last, y_last, ci_last, co_last, kv_last, kh_last;
   logic c_kv, c_co, c_ci, c_y, c_x, last_pair;

   logic inflight_q;
   logic pad_q;
   logic issue;
   logic pop;
   logic [1:0] occ;
   logic [2:0] load;

   logic signed [32:0]   iy, ix, fm_lin;
   logic [CNT_WIDTH-1:0] k_lin;
   logic                 in_range;

   logic                     fifo_full, fifo_empty;
   logic [DW2-1:0]           fifo_wdata, fifo_rdata;
   logic [IO_DATA_WIDTH-1:0] a_fill;

   // Loop-nest wrap detection; carries ripple from k_h (innermost) out to x.
   assign kh_last   = (kh_q == K_C - 1);
   assign kv_last   = (kv_q == K_C - 1);
   assign co_last   = (co_q == COUT_C - 1);
   assign ci_last   = (ci_q == CIN_C - 1);
   assign y_last    = (y_q  == H_C - 1);
   assign x_last    = (x_q  == W_C - 1);
   assign c_kv      = kh_last;
   assign c_co      = c_kv & kv_last;
   assign c_ci      = c_co & co_last;
   assign c_y       = c_ci & ci_last;
   assign c_x       = c_y & y_last;
   assign last_pair = c_x & x_last;

   // Address generation with signed bounds check for the zero-padded border.
   assign iy       = signed'(33'(y_q)) + signed'(33'(kv_q)) - PAD_S;
   assign ix       = signed'(33'(x_q)) + signed'(33'(kh_q)) - PAD_S;
   assign in_range = in_bounds(iy, H_S) && in_bounds(ix, W_S);
   assign fm_lin   = (iy * W_S + ix) * CIN_S + signed'(33'(ci_q));
   assign k_lin    = ((co_q * CIN_C + ci_q) * K_C + kv_q) * K_C + kh_q;

   // Credit check counts the FIFO after this cycle's pop, so a steady stream
   // with ready high sustains one issue per cycle without ever exceeding two
   // outstanding operands. The first read issues in the start cycle itself.
   assign pop   = !rst_in && !fifo_empty && a_ready && b_ready;
   assign occ   = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
   assign load  = 3'(occ) + 3'(inflight_q) - 3'(pop);
   assign issue = !rst_in && (load < 3'd2) &&
                  ((state_q == STREAM) || ((state_q == IDLE) && start));

   assign fm_re   = issue && in_range;
   assign fm_addr = fm_re ? ADDR_WIDTH'(fm_lin) : '0;
   assign k_re    = issue;
   assign k_addr  = issue ? ADDR_WIDTH'(k_lin) : '0;

   assign a_fill     = pad_q ? '0 : fm_rdata;
   assign fifo_wdata = {a_fill, k_rdata};

   operand_fifo #(
      .WIDTH (DW2)
   ) u_fifo (
      .clk    (clk),
      .rst_in (rst_in),
      .push   (inflight_q),
      .wdata  (fifo_wdata),
      .pop    (pop),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign a_valid = !rst_in && !fifo_empty;
   assign b_valid = a_valid;
   assign a_data  = a_valid ? fifo_rdata[DW2-1:IO_DATA_WIDTH] : '0;
   assign b_data  = a_valid ? fifo_rdata[IO_DATA_WIDTH-1:0]   : '0;
   assign running = !rst_in && (state_q != IDLE);
   assign done    = !rst_in && done_c;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and done pulse.
   always_comb begin
      state_d = state_q;
      done_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (issue && last_pair) ? DRAIN : STREAM;
            end
         end
         STREAM: begin
            if (issue && last_pair) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty && !inflight_q) begin
               state_d = IDLE;
               done_c  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read-return tracking: one-cycle memory latency plus padding marker.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         inflight_q <= 1'b0;
         pad_q      <= 1'b0;
      end else begin
         inflight_q <= issue;
         pad_q      <= issue && !in_range;
      end
   end

   // Loop counters step only on issue and wrap to zero after their last value.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         x_q  <= '0;
         y_q  <= '0;
         ci_q <= '0;
         co_q <= '0;
         kv_q <= '0;
         kh_q <= '0;
      end else if (issue) begin
         kh_q <= kh_last ? '0 : kh_q + 1'b1;
         if (c_kv) kv_q <= kv_last ? '0 : kv_q + 1'b1;
         if (c_co) co_q <= co_last ? '0 : co_q + 1'b1;
         if (c_ci) ci_q <= ci_last ? '0 : ci_q + 1'b1;
         if (c_y)  y_q  <= y_last  ? '0 : y_q  + 1'b1;
         if (c_x)  x_q  <= x_last  ? '0 : x_q  + 1'b1;
      end
   end

endmodule

// File: tb/tb_operand_feeder.sv
// Randomised self-checking bench for operand_feeder (W=H=4, Cin=Cout=2, K=3).
module tb_operand_feeder;

   localparam int W     = 4;
   localparam int H     = 4;
   localparam int CIN   = 2;
   localparam int COUT  = 2;
   localparam int K     = 3;
   localparam int TOTAL = W * H * CIN * COUT * K * K;

   logic        clk = 1'b0;
   logic        rst_in, start;
   logic        running, done;
   logic        fm_re, k_re;
   logic [31:0] fm_addr, k_addr;
   logic [7:0]  fm_rdata, k_rdata;
   logic        a_valid, b_valid, a_ready, b_ready;
   logic [7:0]  a_data, b_data;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   int unsigned start_cyc = 0;
   int unsigned iss_n = 0, xfer_n = 0;
   int unsigned first_xfer_cyc = 0, last_xfer_cyc = 0;
   int unsigned done_cnt = 0;
   int          mode = 0;  // 0 ready high, 1 toggle, 2 random, 3 ready low
   bit          first_seen = 0;
   bit          pend = 0;
   logic [7:0]  pend_a, pend_b;

   operand_feeder #(
      .FEATURE_MAP_WIDTH  (W),
      .FEATURE_MAP_HEIGHT (H),
      .INPUT_NB_CHANNELS  (CIN),
      .OUTPUT_NB_CHANNELS (COUT),
      .KERNEL_SIZE        (K),
      .IO_DATA_WIDTH      (8),
      .ADDR_WIDTH         (32)
   ) dut (
      .clk(clk), .rst_in(rst_in), .start(start), .running(running), .done(done),
      .fm_re(fm_re), .fm_addr(fm_addr), .fm_rdata(fm_rdata),
      .k_re(k_re), .k_addr(k_addr), .k_rdata(k_rdata),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [7:0] fm_val(input int unsigned a);
      return 8'((a * 37 + 11) ^ (a >> 2));
   endfunction

   function automatic logic [7:0] k_val(input int unsigned a);
      return 8'(a * 29 + 101);
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference: decompose pair index n by the loop order x,y,ch_in,ch_out,k_v,k_h.
   task automatic model(input int unsigned n, output bit inr, output int unsigned fa,
                        output int unsigned ka, output logic [7:0] ea, output logic [7:0] eb);
      int kh, kv, co, ci, y, x, iy, ix;
      kh = int'(n % K);
      kv = int'((n / K) % K);
      co = int'((n / (K * K)) % COUT);
      ci = int'((n / (K * K * COUT)) % CIN);
      y  = int'((n / (K * K * COUT * CIN)) % H);
      x  = int'(n / (K * K * COUT * CIN * H));
      iy = y + kv - (K - 1) / 2;
      ix = x + kh - (K - 1) / 2;
      inr = (iy >= 0) && (iy < H) && (ix >= 0) && (ix < W);
      fa  = inr ? int'(unsigned'((iy * W + ix) * CIN + ci)) : 0;
      ka  = int'(unsigned'(((co * CIN + ci) * K + kv) * K + kh));
      ea  = inr ? fm_val(fa) : 8'd0;
      eb  = k_val(ka);
   endtask

   // Memories with one-cycle read latency.
   initial begin
      bit rd_fm, rd_k;
      int unsigned a1, a2;
      fm_rdata = '0;
      k_rdata  = '0;
      forever begin
         @(negedge clk);
         rd_fm = fm_re; a1 = fm_addr;
         rd_k  = k_re;  a2 = k_addr;
         @(posedge clk);
         #1;
         if (rd_fm) fm_rdata = fm_val(a1);
         if (rd_k)  k_rdata  = k_val(a2);
      end
   end

   // Consumer ready patterns.
   initial begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0: begin a_ready = 1'b1; b_ready = 1'b1; end
            1: begin a_ready = ~a_ready; b_ready = a_ready; end
            2: begin a_ready = ($urandom % 4) != 0; b_ready = ($urandom % 4) != 0; end
            default: begin a_ready = 1'b0; b_ready = 1'b0; end
         endcase
      end
   end

   // Compare process: checks every cycle against the reference model.
   initial forever begin
      bit inr, xfer;
      int unsigned fa, ka;
      logic [7:0] ea, eb;
      @(negedge clk);
      if (rst_in) begin
         chk("reset_outputs_zero",
             longint'(running | done | fm_re | k_re | a_valid | b_valid |
                      (|fm_addr) | (|k_addr) | (|a_data) | (|b_data)), 0);
         iss_n = 0; xfer_n = 0; pend = 0; first_seen = 0;
      end else begin
         chk("outstanding_le2", longint'((iss_n - xfer_n) <= 2), 1);
         if (a_valid || b_valid) chk("valid_joint", a_valid, b_valid);
         if (pend) begin
            chk("hold_valid", a_valid, 1);
            chk("hold_a_data", a_data, pend_a);
            chk("hold_b_data", b_data, pend_b);
         end
         if (k_re) begin
            model(iss_n, inr, fa, ka, ea, eb);
            chk("k_addr", k_addr, ka);
            chk("fm_re", fm_re, inr);
            if (inr) chk("fm_addr", fm_addr, fa);
            if (iss_n == 0) chk("pair0_fm_re_low", fm_re, 0);
            if (iss_n == 4) begin
               chk("pair4_fm_addr", fm_addr, 0);
               chk("pair4_k_addr", k_addr, 4);
            end
            if (iss_n == 13) chk("pair13_k_addr", k_addr, 22);
            iss_n++;
         end else if (fm_re) begin
            chk("fm_re_without_k_re", k_re, 1);
         end
         if (a_valid && !first_seen) begin
            first_seen = 1;
            chk("first_valid_latency", longint'(cyc) - longint'(start_cyc), 2);
         end
         xfer = a_valid && a_ready && b_valid && b_ready;
         if (xfer) begin
            model(xfer_n, inr, fa, ka, ea, eb);
            chk("a_data", a_data, ea);
            chk("b_data", b_data, eb);
            if (xfer_n == 0) chk("pair0_a_zero", a_data, 0);
            if (xfer_n == 4) chk("pair4_a_data", a_data, 11);
            if (xfer_n == 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            xfer_n++;
         end
         pend   = a_valid && !xfer;
         pend_a = a_data;
         pend_b = b_data;
         if (done) begin
            chk("done_pairs", xfer_n, TOTAL);
            chk("done_issues", iss_n, TOTAL);
            chk("done_after_last", longint'(cyc) - longint'(last_xfer_cyc), 1);
            done_cnt++;
            iss_n = 0; xfer_n = 0; first_seen = 0;
         end
      end
   end

   task automatic run_start();
      @(posedge clk);
      #1;
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      int unsigned d0;
      bit seen;
      d0 = done_cnt;
      seen = 0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         if (done_cnt > d0) begin
            seen = 1;
            break;
         end
      end
      if (!seen) chk("done_timeout", 0, 1);
      @(negedge clk);
      chk("idle_after_done", running, 0);
   endtask

   task automatic wait_xfers(input int unsigned n);
      bit seen;
      seen = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (xfer_n >= n) begin
            seen = 1;
            break;
         end
      end
      if (!seen) chk("xfer_wait_timeout", 0, 1);
   endtask

   // Scenario sequence.
   initial begin
      rst_in = 1'b1;
      start  = 1'b0;
      mode   = 0;
      repeat (3) @(posedge clk);
      #1 rst_in = 1'b0;

      // Ready held high: back-to-back stream.
      run_start();
      wait_done();
      chk("consecutive_xfers", longint'(last_xfer_cyc) - longint'(first_xfer_cyc), TOTAL - 1);

      // Ready toggling every cycle.
      mode = 1;
      run_start();
      wait_done();

      // Ten-cycle stall mid-stream.
      mode = 0;
      run_start();
      wait_xfers(200);
      mode = 3;
      repeat (10) @(negedge clk);
      chk("stall_outstanding", iss_n - xfer_n, 2);
      chk("stall_no_read", k_re, 0);
      mode = 0;
      wait_done();

      // Reset around pair 100, then a clean restart.
      run_start();
      wait_xfers(100);
      @(posedge clk);
      #1 rst_in = 1'b1;
      @(posedge clk);
      #1 rst_in = 1'b0;
      @(negedge clk);
      chk("post_reset_zero",
          longint'(running | done | fm_re | k_re | a_valid | b_valid |
                   (|fm_addr) | (|k_addr) | (|a_data) | (|b_data)), 0);
      run_start();
      wait_done();

      // Random ready with a spurious start pulse while streaming.
      mode = 2;
      run_start();
      repeat (50) @(posedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      chk("running_at_extra_start", running, 1);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done();

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, got running=%0d, expected finish", running);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "time limit");
   end

endmodule
